// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register with valid/ready handshake, flush, hold and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to build the 2-entry skid version with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned           DATA_W  = 64,
    parameter logic [DATA_W-1:0]     RST_VAL = {DATA_W{1'b0}},
    parameter int unsigned           CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic accept;
    logic pop;

    assign pop    = out_valid & out_ready & ~hold;
    assign accept = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              main_free;

    // in_ready comes only from registered state; rst gating keeps it low during reset.
    assign in_ready  = ~skid_valid & ~hold & rst;
    assign main_free = ~out_valid | pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!hold) begin
            if (main_free) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // NOTE: payload registers are reset to RST_VAL but never cleared by flush; only valid bits are killed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= RST_VAL;
            skid_data <= RST_VAL;
        end else if (!flush && !hold) begin
            if (main_free) begin
                if (skid_valid) begin
                    out_data <= skid_data;
                end else if (accept) begin
                    out_data <= in_data;
                end
            end else if (accept) begin
                skid_data <= in_data;
            end
        end
    end
`else
    // Single entry: ready looks through to out_ready combinationally.
    assign in_ready = (~out_valid | out_ready) & ~hold & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!hold) begin
            if (accept) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= RST_VAL;
        end else if (!flush && !hold && accept) begin
            out_data <= in_data;
        end
    end
`endif

    // Backpressure profiling: counts cycles a valid beat is refused downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !hold && !flush && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner sequences and a
// randomized run against a queue-based reference model. Works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int unsigned   DW   = 8;
    localparam int unsigned   CW   = 3;
    localparam logic [DW-1:0] RVAL = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] stall_cnt;

    pipe_stage_reg #(.DATA_W(DW), .RST_VAL(RVAL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of held beats, the last visible payload and the counter.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_last = RVAL;
    int            m_cnt  = 0;

    logic          obs_valid, obs_ready;
    logic [DW-1:0] obs_data;
    logic [CW-1:0] obs_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit h, input bit ordy);
`ifdef PIPE_STAGE_SKID_EN
        return (mq.size() < 2) && !h;
`else
        return ((mq.size() == 0) || ordy) && !h;
`endif
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_last = RVAL;
        m_cnt  = 0;
    endfunction

    // One cycle: drive after the falling edge, compare before the rising edge, advance the model.
    task automatic step(input bit h, input bit f, input bit iv, input logic [DW-1:0] d,
                        input bit ordy, input bit clr);
        bit acc, pv;
        int sz;
        hold = h; flush = f; in_valid = iv; in_data = d; out_ready = ordy; cnt_clr = clr;
        #1;
        obs_valid = out_valid; obs_ready = in_ready; obs_data = out_data; obs_cnt = stall_cnt;
        sz = mq.size();
        check("out_valid", 32'(out_valid), 32'(sz > 0));
        check("out_data", 32'(out_data), 32'((sz > 0) ? mq[0] : m_last));
        check("in_ready", 32'(in_ready), 32'(model_ready(h, ordy)));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        acc = iv && model_ready(h, ordy);
        pv  = (sz > 0) && ordy && !h;
        @(posedge clk);
        if (sz > 0) m_last = mq[0];
        if (f) begin
            mq.delete();
        end else if (!h) begin
            if (pv) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        if (clr) m_cnt = 0;
        else if (sz > 0 && !ordy && !h && !f && m_cnt < (1 << CW) - 1) m_cnt++;
        @(negedge clk);
    endtask

    typedef struct {
        bit            in_valid;
        logic [DW-1:0] in_data;
        bit            out_ready;
        bit            exp_valid;
        logic [DW-1:0] exp_data;
        bit            exp_ready;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Streaming vectors: 1..8 back to back, each visible one cycle after its accept.
        for (int i = 0; i < 10; i++) begin
            tbl[i].in_valid  = (i < 8);
            tbl[i].in_data   = DW'(i + 1);
            tbl[i].out_ready = 1'b1;
            tbl[i].exp_valid = (i >= 1 && i <= 8);
            tbl[i].exp_data  = (i == 0) ? RVAL : DW'((i > 8) ? 8 : i);
            tbl[i].exp_ready = 1'b1;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(RVAL));
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Streaming
        for (int i = 0; i < 10; i++) begin
            step(0, 0, tbl[i].in_valid, tbl[i].in_data, tbl[i].out_ready, 0);
            check("stream_valid", 32'(obs_valid), 32'(tbl[i].exp_valid));
            check("stream_data", 32'(obs_data), 32'(tbl[i].exp_data));
            check("stream_ready", 32'(obs_ready), 32'(tbl[i].exp_ready));
            check("stream_cnt", 32'(obs_cnt), 32'd0);
        end

        // Backpressure: A then B, out_ready low for two cycles while A is shown
        step(0, 0, 1, 8'h11, 1, 0);
        step(0, 0, 1, 8'h22, 0, 0);
        step(0, 0, 1, 8'h22, 0, 0);
        check("bp_in_ready_low", 32'(obs_ready), 32'd0);
        check("bp_hold_a", 32'(obs_data), 32'h11);
        step(0, 0, 1, 8'h22, 1, 0);
        check("bp_out_a", 32'(obs_data), 32'h11);
        step(0, 0, 0, 8'h00, 1, 0);
        check("bp_out_b", 32'(obs_data), 32'h22);
        check("bp_out_b_valid", 32'(obs_valid), 32'd1);
        check("bp_stall_cnt", 32'(obs_cnt), 32'd2);
        step(0, 0, 0, 8'h00, 1, 0);
        check("bp_drained", 32'(obs_valid), 32'd0);

        // Flush while full, with a beat offered in the flush cycle
        step(0, 1, 0, 8'h00, 1, 1);
        step(0, 0, 1, 8'h31, 0, 0);
        step(0, 0, 1, 8'h32, 0, 0);
        step(0, 1, 1, 8'h33, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 8'h00, 1, 0);
            check("flush_empty", 32'(obs_valid), 32'd0);
        end

        // Hold for three cycles, then release, then hold together with flush
        step(0, 0, 1, 8'h44, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 8'h55, 1, 0);
            check("hold_in_ready", 32'(obs_ready), 32'd0);
            check("hold_valid", 32'(obs_valid), 32'd1);
            check("hold_data", 32'(obs_data), 32'h44);
        end
        step(0, 0, 1, 8'h55, 1, 0);
        check("hold_release_a", 32'(obs_data), 32'h44);
        step(0, 0, 0, 8'h00, 0, 0);
        check("hold_release_b", 32'(obs_data), 32'h55);
        step(1, 1, 1, 8'h66, 0, 0);
        step(0, 0, 0, 8'h00, 1, 0);
        check("hold_flush_empty", 32'(obs_valid), 32'd0);

        // Counter saturation and clear
        step(0, 0, 0, 8'h00, 1, 1);
        step(0, 0, 1, 8'h77, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'h00, 0, 0);
        step(0, 0, 0, 8'h00, 0, 1);
        check("sat_cnt", 32'(obs_cnt), 32'd7);
        step(0, 0, 0, 8'h00, 0, 0);
        check("sat_clr", 32'(obs_cnt), 32'd0);

        // Asynchronous reset between edges while the stage holds data
        step(0, 1, 0, 8'h00, 1, 1);
        step(0, 0, 1, 8'h81, 0, 0);
        step(0, 0, 1, 8'h82, 0, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'(RVAL));
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(0, 0, 0, 8'h00, 1, 0);
        check("arst_skid_empty", 32'(obs_ready), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
